// File: rtl/ctrl_seq.sv
// Table-driven control sequencer: each opcode selects a table entry that issues
// 1..2**CNTW beats of a fixed control word over a valid/ready output handshake.
module ctrl_seq #(
    parameter int OPW   = 7,
    parameter int CTRLW = 26,
    parameter int CNTW  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [OPW-1:0]            cfg_addr,
    input  logic [1+CNTW+CTRLW-1:0]   cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPW-1:0]            in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRLW-1:0]          out_ctrl,
    output logic [CNTW-1:0]           out_idx,
    output logic                      out_last,
    output logic                      err,
    output logic                      busy
);

    localparam int DEPTH = 2 ** OPW;
    localparam int ENTW  = 1 + CNTW + CTRLW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_r;
    logic [ENTW-1:0]    tbl_r [DEPTH];
    logic [CTRLW-1:0]   ctrl_r;
    logic [CNTW-1:0]    cnt_r;
    logic [CNTW-1:0]    idx_r;
    logic               err_r;

    logic [ENTW-1:0]    entry_s;
    logic               entry_vld_s;
    logic [CNTW-1:0]    entry_cnt_s;
    logic [CTRLW-1:0]   entry_ctrl_s;
    logic               last_s;
    logic               ready_s;
    logic               accept_s;

    // Combinational lookup plus handshake decode; the lookup sees pre-write table contents.
    always_comb begin
        entry_s      = tbl_r[in_op];
        entry_vld_s  = entry_s[ENTW-1];
        entry_cnt_s  = entry_s[CTRLW +: CNTW];
        entry_ctrl_s = entry_s[CTRLW-1:0];
        last_s       = 1'b0;
        ready_s      = 1'b0;
        if (state_r == ISSUE) begin
            last_s  = (idx_r == cnt_r);
            ready_s = last_s && out_ready;
        end else begin
            last_s  = 1'b0;
            ready_s = 1'b1;
        end
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            ready_s = ready_s;
        end
        accept_s = in_valid && ready_s;
    end

    // Table storage and sequencer FSM with registered beat state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ctrl_r  <= '0;
            cnt_r   <= '0;
            idx_r   <= '0;
            err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                tbl_r[cfg_addr] <= cfg_data;
            end
            err_r <= 1'b0;
            case (state_r)
                IDLE, ISSUE: begin
                    if (state_r == ISSUE && !(last_s && out_ready)) begin
                        // Mid-sequence: advance only when the consumer takes the beat.
                        if (out_ready) begin
                            idx_r <= idx_r + CNTW'(1);
                        end
                    end else if (accept_s && entry_vld_s) begin
                        state_r <= ISSUE;
                        ctrl_r  <= entry_ctrl_s;
                        cnt_r   <= entry_cnt_s;
                        idx_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                        ctrl_r  <= '0;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        err_r   <= accept_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ctrl_r  <= '0;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = (state_r == ISSUE);
    assign busy      = (state_r == ISSUE);
    assign out_ctrl  = ctrl_r;
    assign out_idx   = idx_r;
    assign out_last  = last_s;
    assign err       = err_r;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq with hand-computed expectations.
module tb_ctrl_seq;

    localparam int OPW   = 7;
    localparam int CTRLW = 26;
    localparam int CNTW  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [OPW-1:0]     cfg_addr;
    logic [30:0]        cfg_data;
    logic               in_valid;
    logic               in_ready;
    logic [OPW-1:0]     in_op;
    logic               out_valid;
    logic               out_ready;
    logic [CTRLW-1:0]   out_ctrl;
    logic [CNTW-1:0]    out_idx;
    logic               out_last;
    logic               err;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [25:0] A = 26'h0ABCDEF;
    localparam logic [25:0] X = 26'h1111111;
    localparam logic [25:0] Y = 26'h2222222;
    localparam logic [25:0] Z = 26'h3333333;
    localparam logic [25:0] W = 26'h0F0F0F0;

    ctrl_seq #(.OPW(OPW), .CTRLW(CTRLW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_idx(out_idx), .out_last(out_last), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full output state of one cycle.
    task automatic beat(input string tag, input logic v, input logic [25:0] c,
                        input logic [3:0] i, input logic l, input logic e, input logic r);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".busy"},  64'(busy),      64'(v));
        check({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
        check({tag, ".idx"},   64'(out_idx),   64'(i));
        check({tag, ".last"},  64'(out_last),  64'(l));
        check({tag, ".err"},   64'(err),       64'(e));
        check({tag, ".rdy"},   64'(in_ready),  64'(r));
    endtask

    task automatic wr(input logic [6:0] a, input logic [30:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_op = '0; out_ready = 1'b1;
        tick();
        // cfg write during reset must be dropped
        cfg_we = 1'b1; cfg_addr = 7'd7; cfg_data = {1'b1, 4'd0, X};
        tick();
        cfg_we = 1'b0;
        beat("reset", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("post_reset.rdy", 64'(in_ready), 64'd1);

        // REQ-045 invalid opcode after reset
        in_valid = 1'b1; in_op = 7'd9;
        tick();
        in_valid = 1'b0;
        beat("err9", 1'b0, 26'h0, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        beat("err9_end", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in_op = 7'd7;
        tick();
        in_valid = 1'b0;
        check("rst_cfg_ignored.err", 64'(err), 64'd1);

        // REQ-044 three-beat sequence
        wr(7'd5, {1'b1, 4'd2, A});
        in_valid = 1'b1; in_op = 7'd5;
        tick();
        in_valid = 1'b0; in_op = 7'd9;
        beat("s44_b0", 1'b1, A, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        beat("s44_b1", 1'b1, A, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        beat("s44_b2", 1'b1, A, 4'd2, 1'b1, 1'b0, 1'b1);
        tick();
        beat("s44_idle", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b1);

        // REQ-046 backpressure at idx 1
        in_valid = 1'b1; in_op = 7'd5;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            beat("s46_hold", 1'b1, A, 4'd1, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        beat("s46_b2", 1'b1, A, 4'd2, 1'b1, 1'b0, 1'b1);
        tick();
        beat("s46_idle", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b1);

        // REQ-047 back-to-back sequences
        wr(7'd3, {1'b1, 4'd0, X});
        wr(7'd4, {1'b1, 4'd1, Y});
        in_valid = 1'b1; in_op = 7'd3;
        tick();
        beat("s47_x", 1'b1, X, 4'd0, 1'b1, 1'b0, 1'b1);
        in_op = 7'd4;
        tick();
        in_valid = 1'b0;
        beat("s47_y0", 1'b1, Y, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        beat("s47_y1", 1'b1, Y, 4'd1, 1'b1, 1'b0, 1'b1);
        tick();
        beat("s47_idle", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b1);

        // REQ-035 last beat with simultaneous invalid accept
        in_valid = 1'b1; in_op = 7'd3;
        tick();
        in_op = 7'd9;
        tick();
        in_valid = 1'b0;
        beat("s35", 1'b0, 26'h0, 4'd0, 1'b0, 1'b1, 1'b1);

        // REQ-048 rewrite of the in-flight entry
        in_valid = 1'b1; in_op = 7'd5;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 7'd5; cfg_data = {1'b1, 4'd0, Z};
        tick();
        cfg_we = 1'b0;
        beat("s48_b1", 1'b1, A, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        beat("s48_b2", 1'b1, A, 4'd2, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b1; in_op = 7'd5;
        // REQ-021 collision: accept sees Z while entry 5 is rewritten to A
        cfg_we = 1'b1; cfg_addr = 7'd5; cfg_data = {1'b1, 4'd2, A};
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        beat("s48_z", 1'b1, Z, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        beat("s21_new", 1'b1, A, 4'd0, 1'b0, 1'b0, 1'b0);

        // REQ-049 reset mid-sequence
        tick();
        check("s49_pre.idx", 64'(out_idx), 64'd1);
        rst = 1'b1;
        tick();
        beat("s49_rst", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        in_valid = 1'b1; in_op = 7'd5;
        tick();
        in_valid = 1'b0;
        beat("s49_err", 1'b0, 26'h0, 4'd0, 1'b0, 1'b1, 1'b1);

        // REQ-032 maximum count, in_op wiggled mid-sequence
        wr(7'd6, {1'b1, 4'hF, W});
        in_valid = 1'b1; in_op = 7'd6;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_op = 7'($urandom_range(0, 127));
            beat("s32", 1'b1, W, 4'(k), (k == 15), 1'b0, (k == 15));
            tick();
        end
        beat("s32_idle", 1'b0, 26'h0, 4'd0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
